// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int CNT_W_DEF = 32;
  localparam int WAIT_W = 16;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load in EX
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       hazard
);
  assign hazard = ex_memread_i && ex_rd_i != REG_X0 &&
                  (ex_rd_i == id_rs1_i || (id_uses_rs2_i && ex_rd_i == id_rs2_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer with start FSM, memory timeout and perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             id_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             wb_valid_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             mem_timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);
  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic hazard, active, mem_stall;
  load_use_detect u_lud (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_memread_i  (ex_memread_i),
    .ex_rd_i       (ex_rd_i),
    .hazard        (hazard)
  );
  assign active = state == RUN || state == MEM_WAIT;
  assign mem_stall = active && mem_req_i && !mem_ack_i;
  assign state_o = state;
  assign mem_timeout_o = state == ERROR;
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    pc_write_o = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o = 1'b1;
    if (state == IDLE) begin
      state_nxt = start_i ? RUN : IDLE;
    end else if (mem_stall) begin
      state_nxt = MEM_WAIT;
      if (state == MEM_WAIT) begin
        wait_nxt = wait_cnt + 1'b1;
        state_nxt = wait_nxt == TIMEOUT ? ERROR : MEM_WAIT;
      end
    end else if (active) begin
      // a load-use stall masks the branch: its operands are stale this cycle
      state_nxt = RUN;
      wait_nxt = '0;
      pipe_hold_o = 1'b0;
      pc_write_o = !hazard;
      ifid_write_o = !hazard;
      idex_bubble_o = hazard;
      ifid_flush_o = !hazard && id_branch_taken_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      wait_cnt <= '0;
      stall_cnt_o <= '0;
      retire_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      if (active && !pc_write_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + ONE;
      if (wb_valid_i && !pipe_hold_o && retire_cnt_o != '1) retire_cnt_o <= retire_cnt_o + ONE;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl (CNT_W=4, MEM_TIMEOUT=4)
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_i, start_i, id_uses_rs2_i, ex_memread_i, id_branch_taken_i;
  logic mem_req_i, mem_ack_i, wb_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, mem_timeout_o;
  logic [1:0] state_o;
  logic [3:0] stall_cnt_o, retire_cnt_o;
  typedef struct {
    logic [1:0] st;
    logic pw, iw, fl, bb, ph, to;
    logic [3:0] sc, rc;
  } exp_t;
  exp_t sb[$];
  logic [3:0] exp_stall = '0;
  logic [3:0] exp_ret = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .ex_memread_i      (ex_memread_i),
    .ex_rd_i           (ex_rd_i),
    .id_branch_taken_i (id_branch_taken_i),
    .mem_req_i         (mem_req_i),
    .mem_ack_i         (mem_ack_i),
    .wb_valid_i        (wb_valid_i),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_bubble_o     (idex_bubble_o),
    .pipe_hold_o       (pipe_hold_o),
    .mem_timeout_o     (mem_timeout_o),
    .state_o           (state_o),
    .stall_cnt_o       (stall_cnt_o),
    .retire_cnt_o      (retire_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // push this cycle's expectation, compare once combinational outputs settle, then advance the counter model
  task automatic cyc(input logic [1:0] st, input logic pw, input logic iw, input logic fl,
                     input logic bb, input logic ph);
    exp_t e;
    e.st = st; e.pw = pw; e.iw = iw; e.fl = fl; e.bb = bb; e.ph = ph;
    e.to = st == 2'd3; e.sc = exp_stall; e.rc = exp_ret;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("state", 32'(state_o), 32'(e.st));
    chk("pc_write", 32'(pc_write_o), 32'(e.pw));
    chk("ifid_write", 32'(ifid_write_o), 32'(e.iw));
    chk("ifid_flush", 32'(ifid_flush_o), 32'(e.fl));
    chk("idex_bubble", 32'(idex_bubble_o), 32'(e.bb));
    chk("pipe_hold", 32'(pipe_hold_o), 32'(e.ph));
    chk("mem_timeout", 32'(mem_timeout_o), 32'(e.to));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(e.sc));
    chk("retire_cnt", 32'(retire_cnt_o), 32'(e.rc));
    if (rst_i) begin
      exp_stall = '0;
      exp_ret = '0;
    end else begin
      if ((st == 2'd1 || st == 2'd2) && !pw && exp_stall != 4'hf) exp_stall = exp_stall + 4'd1;
      if (wb_valid_i && !ph && exp_ret != 4'hf) exp_ret = exp_ret + 4'd1;
    end
    @(negedge clk);
  endtask
  task automatic clr();
    ex_memread_i = 0; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    id_uses_rs2_i = 0; id_branch_taken_i = 0;
  endtask
  initial begin
    rst_i = 1; start_i = 0; mem_req_i = 0; mem_ack_i = 0; wb_valid_i = 0;
    clr();
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 1);
    rst_i = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    start_i = 1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 0);
    start_i = 0;
    ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5;
    cyc(1, 0, 0, 0, 1, 0);
    clr();
    cyc(1, 1, 1, 0, 0, 0);
    ex_memread_i = 1; ex_rd_i = 0; id_rs1_i = 0;
    cyc(1, 1, 1, 0, 0, 0);
    ex_rd_i = 7; id_rs1_i = 3; id_rs2_i = 7; id_uses_rs2_i = 0;
    cyc(1, 1, 1, 0, 0, 0);
    id_uses_rs2_i = 1;
    cyc(1, 0, 0, 0, 1, 0);
    clr();
    id_branch_taken_i = 1;
    cyc(1, 1, 1, 1, 0, 0);
    ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5;
    cyc(1, 0, 0, 0, 1, 0);
    clr();
    mem_req_i = 1;
    cyc(1, 0, 0, 0, 0, 1);
    cyc(2, 0, 0, 0, 0, 1);
    cyc(2, 0, 0, 0, 0, 1);
    mem_ack_i = 1;
    cyc(2, 1, 1, 0, 0, 0);
    mem_req_i = 0; mem_ack_i = 0;
    cyc(1, 1, 1, 0, 0, 0);
    mem_req_i = 1; mem_ack_i = 1;
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    mem_req_i = 0; mem_ack_i = 0; wb_valid_i = 1;
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, 0, 0);
    wb_valid_i = 0;
    mem_req_i = 1;
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(2, 0, 0, 0, 0, 1);
    cyc(3, 0, 0, 0, 0, 1);
    mem_ack_i = 1; wb_valid_i = 1;
    cyc(3, 0, 0, 0, 0, 1);
    mem_req_i = 0; mem_ack_i = 0;
    cyc(3, 0, 0, 0, 0, 1);
    rst_i = 1;
    cyc(3, 0, 0, 0, 0, 1);
    rst_i = 0; wb_valid_i = 0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
